// File: rtl/dl_rf_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the integer register
// file's single write port. Round-robin grant among NUM_REQ sources, one
// registered write per cycle, and a pending bitmap for RAW hazard checks.
module dl_rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_val,
  output logic [NUM_REQ-1:0]      req_rdy,
  input  logic [NUM_REQ*AW-1:0]   req_waddr,
  input  logic [NUM_REQ*XLEN-1:0] req_wdata,
  input  logic                    iss_val,
  input  logic [AW-1:0]           iss_waddr,
  output logic                    rf_wval,
  output logic [NREGS-1:0]        rf_wen,
  output logic [AW-1:0]           rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic [NREGS-1:0]        pend
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Requester count at pointer-sum width so the wrap compare stays same-width.
  localparam logic [PW:0] NR = (PW+1)'(NUM_REQ);

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             grant_vld;
  logic [PW-1:0]    grant_idx;
  logic [PW:0]      scan_idx;
  logic [AW-1:0]    sel_waddr;
  logic [XLEN-1:0]  sel_wdata;

  logic             rf_wval_q, rf_wval_d;
  logic [NREGS-1:0] rf_wen_q, rf_wen_d;
  logic [AW-1:0]    rf_waddr_q;
  logic [XLEN-1:0]  rf_wdata_q;
  logic [NREGS-1:0] pend_q, pend_d;

  // Round-robin search from rr_ptr upward with wrap; first valid wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    req_rdy   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = {1'b0, rr_ptr_q} + (PW+1)'(off);
      if (scan_idx >= NR) scan_idx = scan_idx - NR;
      if (!grant_vld && req_val[scan_idx[PW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx[PW-1:0];
      end
    end
    // Reset masks every request so nothing is consumed while it is held.
    if (rst) grant_vld = 1'b0;
    if (grant_vld) req_rdy[grant_idx] = 1'b1;
  end

  assign sel_waddr = req_waddr[grant_idx*AW +: AW];
  assign sel_wdata = req_wdata[grant_idx*XLEN +: XLEN];

  // Pointer moves to one past the winner; holds when nobody transfers.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == PW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // x0 writes are consumed but never strobe the register file.
  assign rf_wval_d = grant_vld && (sel_waddr != '0);

  // Per-register write-enable decode and scoreboard update. A same-cycle
  // issue beats the clear because the new claim is younger than the write.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    if (gi == 0) begin : g_x0
      assign rf_wen_d[gi] = 1'b0;
      assign pend_d[gi]   = 1'b0;
    end else begin : g_xn
      logic hit_wb, hit_iss;
      assign hit_wb       = grant_vld && (sel_waddr == AW'(gi));
      assign hit_iss      = iss_val && (iss_waddr == AW'(gi));
      assign rf_wen_d[gi] = hit_wb;
      assign pend_d[gi]   = hit_iss | (pend_q[gi] & ~hit_wb);
    end
  end

  // State registers; address/data hold their last value between transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      rf_wval_q  <= 1'b0;
      rf_wen_q   <= '0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pend_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rf_wval_q <= rf_wval_d;
      rf_wen_q  <= rf_wen_d;
      pend_q    <= pend_d;
      if (grant_vld) begin
        rf_waddr_q <= sel_waddr;
        rf_wdata_q <= sel_wdata;
      end
    end
  end

  assign rf_wval  = rf_wval_q;
  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign pend     = pend_q;

endmodule

// File: tb/tb_dl_rf_wb_arbiter.sv
// Self-checking bench for dl_rf_wb_arbiter: directed scenarios plus a random
// run, all compared against a transaction-level model of the write port.
module tb_dl_rf_wb_arbiter;

  localparam int N  = 3;
  localparam int XL = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_val;
  logic [N-1:0]    req_rdy;
  logic [N*AW-1:0] req_waddr;
  logic [N*XL-1:0] req_wdata;
  logic            iss_val;
  logic [AW-1:0]   iss_waddr;
  logic            rf_wval;
  logic [NR-1:0]   rf_wen;
  logic [AW-1:0]   rf_waddr;
  logic [XL-1:0]   rf_wdata;
  logic [NR-1:0]   pend;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int            m_ptr;
  bit            m_pend[NR];
  logic          m_wval;
  logic [NR-1:0] m_wen;
  logic [AW-1:0] m_waddr;
  logic [XL-1:0] m_wdata;

  dl_rf_wb_arbiter #(.NUM_REQ(N), .XLEN(XL), .NREGS(NR)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy),
    .req_waddr(req_waddr), .req_wdata(req_wdata),
    .iss_val(iss_val), .iss_waddr(iss_waddr),
    .rf_wval(rf_wval), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .pend(pend)
  );

  always #5 clk = ~clk;

  // Winner by the rule: first valid at or after the pointer, modulo N.
  function automatic int exp_winner();
    if (rst) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_val[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rdy();
    int g;
    logic [N-1:0] r;
    g = exp_winner();
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [NR-1:0] exp_pend();
    logic [NR-1:0] p;
    for (int k = 0; k < NR; k++) p[k] = m_pend[k];
    return p;
  endfunction

  function automatic logic [101:0] exp_out();
    return {m_wval, m_wen, m_waddr, m_wdata, exp_pend()};
  endfunction

  function automatic logic [101:0] dut_out();
    return {rf_wval, rf_wen, rf_waddr, rf_wdata, pend};
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XL-1:0] d);
    req_waddr[i*AW +: AW] = a;
    req_wdata[i*XL +: XL] = d;
  endtask

  // Advance one clock edge and move the model by one transaction.
  task automatic tick();
    int            g;
    logic          iv;
    logic [AW-1:0] ia, a;
    g  = exp_winner();
    iv = iss_val;
    ia = iss_waddr;
    a  = (g >= 0) ? req_waddr[g*AW +: AW] : '0;
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_wval = 0; m_wen = '0; m_waddr = '0; m_wdata = '0;
      for (int k = 0; k < NR; k++) m_pend[k] = 0;
    end else begin
      if (g >= 0) begin
        m_ptr   = (g + 1) % N;
        m_wval  = (a != 0);
        m_wen   = (a != 0) ? (NR'(1) << a) : '0;
        m_waddr = a;
        m_wdata = req_wdata[g*XL +: XL];
        m_pend[a] = 0;
      end else begin
        m_wval = 0;
        m_wen  = '0;
      end
      if (iv && ia != 0) m_pend[ia] = 1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    rst = 0; req_val = '0; iss_val = 0; iss_waddr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; req_val = '0; iss_val = 0;
    tick();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 0; req_val = 3'b111; iss_val = 1; iss_waddr = 5'd9;
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 4), 32'h100 + i);
    for (int c = 0; c < 4; c++) begin tick(); @(negedge clk); end
    rst = 1;
    #1;
    n_vec++;
    if (req_rdy !== 3'b000) begin
      n_err++; $display("FAIL reset_rdy got=%b exp=000", req_rdy);
    end
    tick();
    n_vec++;
    if (rf_wval !== 0 || rf_wen !== '0 || pend !== '0) begin
      n_err++; $display("FAIL reset_out wval=%b wen=%h pend=%h exp 0/0/0", rf_wval, rf_wen, pend);
    end
    @(negedge clk);
    rst = 0; iss_val = 0;
    #1;
    n_vec++;
    if (req_rdy !== 3'b001) begin
      n_err++; $display("FAIL reset_first_grant got=%b exp=001", req_rdy);
    end
    tick();
    n_vec++;
    if (dut_out() !== exp_out()) begin
      n_err++; $display("FAIL reset_model got=%h exp=%h", dut_out(), exp_out());
    end
    $display("test_reset done");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), 32'hA0 + i);
    req_val = 3'b111;
    for (int c = 0; c < 6; c++) begin
      logic [N-1:0] er;
      er = N'(1) << (c % 3);
      #1;
      n_vec++;
      if (req_rdy !== er || req_rdy !== exp_rdy()) begin
        n_err++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, req_rdy, er);
      end
      tick();
      n_vec++;
      if (rf_wen !== (NR'(1) << (c % 3 + 1)) || dut_out() !== exp_out()) begin
        n_err++; $display("FAIL rr_wen cyc=%0d got=%h exp=%h", c, rf_wen, NR'(1) << (c % 3 + 1));
      end
      $display("rr cyc=%0d rdy=%b wen=%h", c, er, rf_wen);
      @(negedge clk);
    end
  endtask

  task automatic test_pointer_skip();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 20), 32'hB0 + i);
    req_val = 3'b001;
    tick();
    @(negedge clk);
    req_val = 3'b101;
    #1;
    n_vec++;
    if (req_rdy !== 3'b100) begin
      n_err++; $display("FAIL skip_to_2 got=%b exp=100", req_rdy);
    end
    tick();
    @(negedge clk);
    #1;
    n_vec++;
    if (req_rdy !== 3'b001) begin
      n_err++; $display("FAIL skip_wrap_0 got=%b exp=001", req_rdy);
    end
    tick();
    n_vec++;
    if (rf_waddr !== 5'd20 || dut_out() !== exp_out()) begin
      n_err++; $display("FAIL skip_out waddr=%0d exp=20", rf_waddr);
    end
    $display("pointer skip done");
    idle_inputs();
  endtask

  task automatic test_x0();
    do_reset();
    set_req(0, 5'd0, 32'hDEADBEEF);
    set_req(1, 5'd3, 32'h33);
    req_val = 3'b001;
    #1;
    n_vec++;
    if (req_rdy !== 3'b001) begin
      n_err++; $display("FAIL x0_rdy got=%b exp=001", req_rdy);
    end
    tick();
    n_vec++;
    if (rf_wval !== 0 || rf_wen !== '0 || dut_out() !== exp_out()) begin
      n_err++; $display("FAIL x0_out wval=%b wen=%h exp 0/0", rf_wval, rf_wen);
    end
    @(negedge clk);
    req_val = 3'b011;
    #1;
    n_vec++;
    if (req_rdy !== 3'b010) begin
      n_err++; $display("FAIL x0_ptr_adv got=%b exp=010", req_rdy);
    end
    tick();
    $display("x0 write done wen=%h", rf_wen);
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    do_reset();
    iss_val = 1; iss_waddr = 5'd5;
    tick();
    n_vec++;
    if (pend !== 32'h20) begin
      n_err++; $display("FAIL sb_set got=%h exp=00000020", pend);
    end
    idle_inputs();
    tick();
    @(negedge clk);
    set_req(2, 5'd5, 32'h55);
    req_val = 3'b100;
    tick();
    n_vec++;
    if (pend !== '0 || rf_wen !== 32'h20 || rf_wval !== 1) begin
      n_err++; $display("FAIL sb_clear pend=%h wen=%h exp 0/00000020", pend, rf_wen);
    end
    @(negedge clk);
    set_req(0, 5'd7, 32'h77);
    req_val = 3'b001; iss_val = 1; iss_waddr = 5'd7;
    tick();
    n_vec++;
    if (pend !== 32'h80 || rf_wen !== 32'h80) begin
      n_err++; $display("FAIL sb_set_wins pend=%h wen=%h exp 80/80", pend, rf_wen);
    end
    @(negedge clk);
    req_val = '0; iss_waddr = 5'd0;
    tick();
    n_vec++;
    if (pend !== 32'h80 || dut_out() !== exp_out()) begin
      n_err++; $display("FAIL sb_x0_iss pend=%h exp=00000080", pend);
    end
    $display("scoreboard done pend=%h", pend);
    idle_inputs();
  endtask

  task automatic test_throughput();
    do_reset();
    req_val = 3'b010;
    for (int c = 0; c < 10; c++) begin
      set_req(1, AW'(10 + c), 32'hC00 + c);
      #1;
      n_vec++;
      if (req_rdy !== 3'b010) begin
        n_err++; $display("FAIL tput_rdy cyc=%0d got=%b exp=010", c, req_rdy);
      end
      tick();
      n_vec++;
      if (rf_wen !== (NR'(1) << (10 + c)) || rf_wdata !== 32'hC00 + c) begin
        n_err++; $display("FAIL tput_wen cyc=%0d got=%h exp=%h", c, rf_wen, NR'(1) << (10 + c));
      end
      $display("tput cyc=%0d wen=%h", c, rf_wen);
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 39) == 0);
      req_val   = N'($urandom);
      iss_val   = $urandom_range(0, 1);
      iss_waddr = AW'($urandom);
      for (int i = 0; i < N; i++) set_req(i, AW'($urandom_range(0, 7)), $urandom);
      #1;
      n_vec++;
      if (req_rdy !== exp_rdy()) begin
        n_err++; bad++; $display("FAIL rand_rdy cyc=%0d got=%b exp=%b", c, req_rdy, exp_rdy());
      end
      tick();
      n_vec++;
      if (dut_out() !== exp_out()) begin
        n_err++; bad++; $display("FAIL rand_out cyc=%0d got=%h exp=%h", c, dut_out(), exp_out());
      end
    end
    $display("random run done, %0d bad", bad);
    idle_inputs();
  endtask

  initial begin
    rst = 1; req_val = '0; req_waddr = '0; req_wdata = '0;
    iss_val = 0; iss_waddr = '0;
    m_ptr = 0; m_wval = 0; m_wen = '0; m_waddr = '0; m_wdata = '0;
    for (int k = 0; k < NR; k++) m_pend[k] = 0;
    tick();
    tick();
    test_reset();
    test_round_robin();
    test_pointer_skip();
    test_x0();
    test_scoreboard();
    test_throughput();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
